// File: rtl/audio_slot_counter_pkg.sv
// Shared definitions for the audio slot counter slice.
//  - clog2: ceiling log2, used for parameter-derived widths
//  - DIR_UP / DIR_DOWN: encoding of the dir input
//  - DEF_*: default geometry shared by the counter and its users
package audio_cnt_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int DEF_WIDTH    = 5;
  localparam int DEF_MODULUS  = 32;
  localparam int DEF_PRESCALE = 1;
  localparam int DEF_CHANNELS = 2;

  // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(3) = 2.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/audio_slot_counter_if.sv
// Control/status bundle of the audio slot counter.
//  master: drives en, clear, load, load_val, dir; observes count, chan, tick, wrap, frame
//  slave : the counter itself (opposite directions)
interface audio_slot_counter_if #(
  parameter int WIDTH = 5,
  parameter int CH_W  = 1
);

  logic             en;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             dir;
  logic [WIDTH-1:0] count;
  logic [CH_W-1:0]  chan;
  logic             tick;
  logic             wrap;
  logic             frame;

  modport master (
    output en, clear, load, load_val, dir,
    input  count, chan, tick, wrap, frame
  );

  modport slave (
    input  en, clear, load, load_val, dir,
    output count, chan, tick, wrap, frame
  );

endinterface

// File: rtl/audio_slot_counter_tick_gen.sv
// Prescaler for the audio slot counter.
//  clk   in  system clock
//  reset in  asynchronous active-low reset
//  en    in  prescaler advances only while high
//  clr   in  synchronous restart of the prescaler phase (clear or load)
//  step  out combinational strobe: this enabled cycle completes a prescale period
// With PRESCALE=1 the phase register is constant 0 and step reduces to en.
module audio_tick_gen
  import audio_cnt_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam int PW = (clog2(PRESCALE) > 1) ? clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(PRESCALE - 1);

  generate
    if (PRESCALE < 1) begin : g_bad_prescale
      $error("audio_tick_gen: PRESCALE must be >= 1");
    end
  endgenerate

  logic [PW-1:0] phase_reg;

  assign step = en && (phase_reg == PHASE_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_reg <= '0;
    end else if (clr) begin
      phase_reg <= '0;
    end else if (en) begin
      phase_reg <= step ? '0 : phase_reg + 1'b1;
    end
  end

endmodule

// File: rtl/audio_slot_counter.sv
// Parametrised modulo slot counter for audio framing.
//  clk   in  system clock, rising edge
//  reset in  asynchronous active-low reset
//  bus   slave side of audio_slot_counter_if:
//        en/clear/load/load_val/dir in; count/chan/tick/wrap/frame out (all registered)
// Edge priority: clear > load > step > hold. Pulses are high in the cycle the
// new count is visible.
module audio_slot_counter
  import audio_cnt_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MODULUS  = DEF_MODULUS,
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int CH_W     = (clog2(CHANNELS) > 1) ? clog2(CHANNELS) : 1
) (
  input logic                  clk,
  input logic                  reset,
  audio_slot_counter_if.slave  bus
);

  generate
    if (MODULUS > (1 << WIDTH)) begin : g_bad_modulus_hi
      $error("audio_slot_counter: MODULUS exceeds 2**WIDTH");
    end
    if (MODULUS < 2) begin : g_bad_modulus_lo
      $error("audio_slot_counter: MODULUS must be >= 2");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
      $error("audio_slot_counter: PRESCALE must be >= 1");
    end
    if (CHANNELS < 1) begin : g_bad_channels
      $error("audio_slot_counter: CHANNELS must be >= 1");
    end
    if (CH_W < clog2(CHANNELS)) begin : g_bad_ch_w
      $error("audio_slot_counter: CH_W too narrow for CHANNELS");
    end
  endgenerate

  localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);
  // CHANNELS=1 gives CH_LAST=0, so chan stays 0 and frame follows wrap.
  localparam logic [CH_W-1:0]  CH_LAST = CH_W'(CHANNELS - 1);

  logic [WIDTH-1:0] count_reg, count_next;
  logic [CH_W-1:0]  chan_reg, chan_next;
  logic             tick_reg, wrap_reg, frame_reg;
  logic             wrap_next, frame_next;
  logic [WIDTH-1:0] load_sat;
  logic             step;

  // Any clear or load restarts the prescale phase.
  audio_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .en    (bus.en),
    .clr   (bus.clear | bus.load),
    .step  (step)
  );

  // Loaded values are saturated so count never leaves 0..MODULUS-1.
  assign load_sat = (bus.load_val > LAST) ? LAST : bus.load_val;

  // Value the registers take if this edge is a step.
  always_comb begin
    count_next = count_reg;
    chan_next  = chan_reg;
    wrap_next  = 1'b0;
    frame_next = 1'b0;
    if (bus.dir == DIR_UP) begin
      if (count_reg == LAST) begin
        count_next = '0;
        wrap_next  = 1'b1;
      end else begin
        count_next = count_reg + 1'b1;
      end
    end else begin
      if (count_reg == '0) begin
        count_next = LAST;
        wrap_next  = 1'b1;
      end else begin
        count_next = count_reg - 1'b1;
      end
    end
    // Channel sequencing always runs forward, whatever the count direction.
    if (wrap_next) begin
      if (chan_reg == CH_LAST) begin
        chan_next  = '0;
        frame_next = 1'b1;
      end else begin
        chan_next = chan_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
      chan_reg  <= '0;
      tick_reg  <= 1'b0;
      wrap_reg  <= 1'b0;
      frame_reg <= 1'b0;
    end else if (bus.clear) begin
      count_reg <= '0;
      chan_reg  <= '0;
      tick_reg  <= 1'b0;
      wrap_reg  <= 1'b0;
      frame_reg <= 1'b0;
    end else if (bus.load) begin
      count_reg <= load_sat;
      tick_reg  <= 1'b0;
      wrap_reg  <= 1'b0;
      frame_reg <= 1'b0;
    end else if (step) begin
      count_reg <= count_next;
      chan_reg  <= chan_next;
      tick_reg  <= 1'b1;
      wrap_reg  <= wrap_next;
      frame_reg <= frame_next;
    end else begin
      tick_reg  <= 1'b0;
      wrap_reg  <= 1'b0;
      frame_reg <= 1'b0;
    end
  end

  assign bus.count = count_reg;
  assign bus.chan  = chan_reg;
  assign bus.tick  = tick_reg;
  assign bus.wrap  = wrap_reg;
  assign bus.frame = frame_reg;

endmodule
